// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM encoding,
// iteration constants and a two's-complement negate helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

  // Two's-complement negation; also yields the magnitude of a negative value.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/subtract_32.sv
// Plain 32-bit subtractor used for the divider's trial subtraction.
module subtract_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out
);

  assign out = A - B;

endmodule

// File: rtl/div_32_iter.sv
// Multi-cycle 32-bit restoring divider (one trial subtraction per clock).
// Optional feature: define DIV_SIGNED_EN for two's-complement operands;
// without it the divider is purely unsigned and carries no sign logic.
module div_32_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_result_rdy,
  output logic             data_exception
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             div0_q;
  logic             busy_q;
  logic             rdy_q;
  logic             exc_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] remainder_q;
`ifdef DIV_SIGNED_EN
  logic             qneg_q;
  logic             rneg_q;
`endif

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] res_out_s;
  logic [WIDTH-1:0] rem_out_s;

  // Trial subtraction of the divisor from the shifted partial remainder.
  subtract_32 u_sub (
    .A   (shifted_s),
    .B   (dvs_q),
    .out (diff_s)
  );

  // Restoring step: keep the difference unless the subtraction borrowed.
  always_comb begin
    shifted_s = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    // Unsigned borrow from operand MSBs and the difference MSB.
    borrow_s  = (~shifted_s[WIDTH-1] & dvs_q[WIDTH-1]) |
                (~(shifted_s[WIDTH-1] ^ dvs_q[WIDTH-1]) & diff_s[WIDTH-1]);
    rem_d     = diff_s;
    quo_d     = {quo_q[WIDTH-2:0], 1'b1};
    if (borrow_s) begin
      rem_d = shifted_s;
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = diff_s;
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Operand magnitudes at load and sign fix-up of the final results.
  always_comb begin
    a_mag_s   = data_a;
    b_mag_s   = data_b;
    res_out_s = quo_q;
    rem_out_s = rem_q;
`ifdef DIV_SIGNED_EN
    if (data_a[WIDTH-1]) begin
      a_mag_s = neg32(data_a);
    end else begin
      a_mag_s = data_a;
    end
    if (data_b[WIDTH-1]) begin
      b_mag_s = neg32(data_b);
    end else begin
      b_mag_s = data_b;
    end
    if (qneg_q) begin
      res_out_s = neg32(quo_q);
    end else begin
      res_out_s = quo_q;
    end
    if (rneg_q) begin
      rem_out_s = neg32(rem_q);
    end else begin
      rem_out_s = rem_q;
    end
`endif
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      div0_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
      exc_q       <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b0;
          if (ctrl_div) begin
            exc_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
            if (data_b == {WIDTH{1'b0}}) begin
              // Divide by zero: skip the iterations, report dividend as remainder.
              state_q <= DONE;
              div0_q  <= 1'b1;
              quo_q   <= {WIDTH{1'b0}};
              rem_q   <= data_a;
`ifdef DIV_SIGNED_EN
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
`endif
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              div0_q  <= 1'b0;
              quo_q   <= a_mag_s;
              rem_q   <= {WIDTH{1'b0}};
              dvs_q   <= b_mag_s;
`ifdef DIV_SIGNED_EN
              qneg_q  <= data_a[WIDTH-1] ^ data_b[WIDTH-1];
              rneg_q  <= data_a[WIDTH-1];
`endif
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          rdy_q       <= 1'b1;
          result_q    <= res_out_s;
          remainder_q <= rem_out_s;
          exc_q       <= div0_q;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign data_result     = result_q;
  assign data_remainder  = remainder_q;
  assign data_result_rdy = rdy_q;
  assign data_exception  = exc_q;

endmodule

// File: tb/tb_div_32_iter.sv
// Directed self-checking bench for div_32_iter (unsigned build by default;
// signed vectors are added when DIV_SIGNED_EN is defined).
module tb_div_32_iter;

  logic        clock;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        busy;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_result_rdy;
  logic        data_exception;

  int tests_run;
  int tests_failed;
  int lat;
  int busy_cycles;
  int rdy_seen;
  logic exc_at_start;

  div_32_iter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ctrl_div        (ctrl_div),
    .data_a          (data_a),
    .data_b          (data_b),
    .busy            (busy),
    .data_result     (data_result),
    .data_remainder  (data_remainder),
    .data_result_rdy (data_result_rdy),
    .data_exception  (data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a divide; optionally pulse a second request at cycle inject_at.
  // Returns cycles from the accepting edge to the rdy sample.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inject_at);
    @(negedge clock);
    data_a   = a;
    data_b   = b;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div     = 1'b0;
    exc_at_start = data_exception;
    data_a       = 32'hDEAD_BEEF;
    data_b       = 32'h0000_0003;
    lat          = 0;
    busy_cycles  = 0;
    while (!data_result_rdy && lat < 100) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      lat++;
      if (lat == inject_at) begin
        data_a   = 32'd50;
        data_b   = 32'd5;
        ctrl_div = 1'b1;
      end else begin
        ctrl_div = 1'b0;
      end
    end
  endtask

  // Watch for stray result pulses over n cycles.
  task automatic watch_rdy(input int n);
    rdy_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (data_result_rdy) rdy_seen++;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n  = 1'b0;
    ctrl_div = 1'b0;
    data_a   = 32'd0;
    data_b   = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {31'd0, data_result_rdy}, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_quo", data_result, 32'd0);
    check("rst_rem", data_remainder, 32'd0);
    reset_n = 1'b1;

    // 100 / 7
    run_div(32'd100, 32'd7, -1);
    check("basic_lat", lat, 32'd33);
    check("basic_quo", data_result, 32'd14);
    check("basic_rem", data_remainder, 32'd2);
    check("basic_exc", {31'd0, data_exception}, 32'd0);
    check("basic_busy", busy_cycles, 32'd32);
    @(negedge clock);
    check("basic_pulse", {31'd0, data_result_rdy}, 32'd0);
    check("basic_hold", data_result, 32'd14);

    // Large dividend
    run_div(32'hFFFF_FFFF, 32'd1, -1);
    check("big_quo", data_result, 32'hFFFF_FFFF);
    check("big_rem", data_remainder, 32'd0);

    // Dividend smaller than divisor
    run_div(32'd5, 32'd9, -1);
    check("small_quo", data_result, 32'd0);
    check("small_rem", data_remainder, 32'd5);

    // All-ones by all-ones (1 r 0 in both signedness modes)
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("ones_quo", data_result, 32'd1);
    check("ones_rem", data_remainder, 32'd0);

    // Divide by zero
    run_div(32'd1234, 32'd0, -1);
    check("dz_lat", lat, 32'd1);
    check("dz_exc", {31'd0, data_exception}, 32'd1);
    check("dz_quo", data_result, 32'd0);
    check("dz_rem", data_remainder, 32'd1234);
    @(negedge clock);
    check("dz_exc_hold", {31'd0, data_exception}, 32'd1);

    // Next start clears the exception
    run_div(32'd8, 32'd2, -1);
    check("clr_exc_start", {31'd0, exc_at_start}, 32'd0);
    check("clr_quo", data_result, 32'd4);
    check("clr_exc", {31'd0, data_exception}, 32'd0);

    // Busy protocol: second request during RUN is dropped
    run_div(32'd1000, 32'd3, 10);
    check("busy_lat", lat, 32'd33);
    check("busy_quo", data_result, 32'd333);
    check("busy_rem", data_remainder, 32'd1);
    check("busy_cnt", busy_cycles, 32'd32);
    watch_rdy(40);
    check("busy_extra_rdy", rdy_seen, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);

    // Reset mid-operation
    @(negedge clock);
    data_a   = 32'd77;
    data_b   = 32'd5;
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_quo", data_result, 32'd0);
    check("mrst_rem", data_remainder, 32'd0);
    check("mrst_rdy", {31'd0, data_result_rdy}, 32'd0);
    reset_n = 1'b1;
    watch_rdy(40);
    check("mrst_no_rdy", rdy_seen, 32'd0);

    run_div(32'd9, 32'd4, -1);
    check("fresh_quo", data_result, 32'd2);
    check("fresh_rem", data_remainder, 32'd1);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFF_FFF9, 32'd2, -1);
    check("s_m7_2_quo", data_result, 32'hFFFF_FFFD);
    check("s_m7_2_rem", data_remainder, 32'hFFFF_FFFF);
    run_div(32'd7, 32'hFFFF_FFFE, -1);
    check("s_7_m2_quo", data_result, 32'hFFFF_FFFD);
    check("s_7_m2_rem", data_remainder, 32'd1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("s_min_lat", lat, 32'd33);
    check("s_min_quo", data_result, 32'h8000_0000);
    check("s_min_rem", data_remainder, 32'd0);
    check("s_min_exc", {31'd0, data_exception}, 32'd0);
`else
    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("u_min_quo", data_result, 32'd0);
    check("u_min_rem", data_remainder, 32'h8000_0000);
    run_div(32'hDEAD_BEEF, 32'h0000_0010, -1);
    check("u_beef_quo", data_result, 32'h0DEA_DBEE);
    check("u_beef_rem", data_remainder, 32'h0000_000F);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_32_iter.md
Name: div_32_iter

Overview:
- Multi-cycle 32-bit restoring divider for the ALU multdiv path.
- Performs one trial subtraction per clock using a subtract_32 instance, which is this block's only sub-module.
- Consumes the subtract_32 difference and its sign each iteration, then returns quotient and remainder with a ready pulse to the pipeline stall logic.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- ctrl_div  in  1  start request; sampled only in IDLE.
- data_a  in  32  dividend; captured when ctrl_div is accepted.
- data_b  in  32  divisor; captured when ctrl_div is accepted.
- busy  out  1  high while in RUN.
- data_result  out  32  quotient.
- data_remainder  out  32  remainder.
- data_result_rdy  out  1  one-cycle pulse; results valid.
- data_exception  out  1  divide-by-zero flag; valid while data_result_rdy is high and held afterwards.

Behaviour:
- Reset (reset_n low at a clock edge): state=IDLE, counter=0. busy, data_result_rdy and data_exception go to 0. data_result and data_remainder go to 0. Reset overrides all other activity, including mid-RUN; no result pulse follows.
- States and transitions:
  - IDLE: ctrl_div=1 and data_b!=0 -> RUN. Load rem=0, quo=data_a, counter=0.
  - IDLE: ctrl_div=1 and data_b==0 -> DONE. data_exception=1, data_result=0, data_remainder=data_a.
  - RUN: one iteration per cycle. shifted = {rem[30:0], quo[31]}; subtract_32 computes shifted - divisor.
    - If the restoring compare finds shifted < divisor (unsigned; use the 33-bit borrow): rem=shifted, quo={quo[30:0],0}.
    - Otherwise: rem=difference, quo={quo[30:0],1}.
    - counter++. After the iteration with counter==31 -> DONE.
  - DONE: data_result_rdy=1 for exactly one cycle; register outputs updated; then -> IDLE.
- Latency:
  - start accepted at edge k; data_result_rdy high in the cycle after edge k+33.
  - Divide-by-zero: ready in the cycle after edge k+1.
- ctrl_div while busy or in DONE is ignored; no queuing.
- ctrl_div may be a level. A new start is accepted on the first IDLE cycle after DONE.
- Outputs hold their last values until the next accepted start completes. data_exception clears at the next accepted start.
- Operands are latched at start; later changes on data_a/data_b have no effect.
- Unsigned arithmetic by default. data_a < data_b gives quotient 0, remainder data_a.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken at load.
  - Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Sign fix-up is applied when writing outputs in DONE; latency is unchanged.
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, no exception.
- Undefined: purely unsigned; no sign logic synthesized.

Decomposition:
- Package div_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - DIV_ITER=32;
  - DIV_CNT_W=6.
- One sub-module: subtract_32 (A, B, out), instanced once for the trial subtraction.
- Borrow is derived from a 33-bit compare alongside it, or from the operand MSBs plus the output MSB.

Test Plan:
- Basic divide: start 100/7 -> rdy pulse 33 cycles after start; quotient 14, remainder 2; exception 0.
- Large dividend: 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0. Then 5/9 -> quotient 0, remainder 5.
- Divide by zero: 1234/0 -> rdy after 1 cycle; exception 1, quotient 0, remainder 1234. The next start, 8/2, clears exception and gives quotient 4.
- Busy protocol: start 1000/3; pulse ctrl_div with 50/5 at cycle 10 -> ignored; one rdy with quotient 333, remainder 1; busy high for 32 cycles.
- Reset mid-operation: reset_n low at cycle 15 of a divide -> all outputs 0 the next cycle, no rdy pulse. A fresh start, 9/4, gives quotient 2, remainder 1.
- With DIV_SIGNED_EN:
  - -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
  - 0x80000000/-1 -> quotient 0x80000000, remainder 0.
